// File: rtl/alu_cmd_pkg.sv
// Shared types and widths for the ALU command server.
package alu_cmd_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_INC    = 3'd2,
    OP_AND    = 3'd3,
    OP_OR     = 3'd4,
    OP_XOR    = 3'd5,
    OP_PASS_A = 3'd6,
    OP_ILL    = 3'd7
  } op_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              cout;
    logic              zero;
    logic              err;
    logic [TAG_W-1:0]  tag;
  } rsp_t;

  // Opcodes whose carry-out feeds the stored chain carry.
  function automatic logic is_arith(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC);
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO; head reads as all-zero while empty.
module alu_rsp_fifo
  import alu_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  rsp_t             push_data,
  input  logic             pop,
  output rsp_t             head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  rsp_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; unread slots are masked by empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_cmd_server.sv
// 16-bit ALU request/response server with chained carry and response FIFO.
module alu_cmd_server
  import alu_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_cin,
  input  logic              req_chain,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_cout,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [TAG_W-1:0]  rsp_tag
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned WIDE_W = DATA_W + 1;

  op_e               op;
  logic              carry_q;
  logic              carry_eff;
  logic              accept;
  logic [WIDE_W-1:0] wide;
  rsp_t              alu_rsp;
  rsp_t              head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  assign op        = op_e'(req_op);
  assign req_ready = ~reset & ~fifo_full;
  assign accept    = req_valid & req_ready;
  assign carry_eff = req_chain ? carry_q : req_cin;

  // Single-cycle datapath evaluated in the accept cycle.
  always_comb begin
    wide        = '0;
    alu_rsp     = '0;
    alu_rsp.tag = req_tag;
    case (op)
      OP_ADD:    wide = WIDE_W'(req_a) + WIDE_W'(req_b) + WIDE_W'(carry_eff);
      OP_SUB:    wide = WIDE_W'(req_a) - WIDE_W'(req_b) - WIDE_W'(carry_eff);
      OP_INC:    wide = WIDE_W'(req_a) + WIDE_W'(1);
      OP_AND:    wide = {1'b0, req_a & req_b};
      OP_OR:     wide = {1'b0, req_a | req_b};
      OP_XOR:    wide = {1'b0, req_a ^ req_b};
      OP_PASS_A: wide = {1'b0, req_a};
      default:   alu_rsp.err = 1'b1;
    endcase
    alu_rsp.result = wide[DATA_W-1:0];
    alu_rsp.cout   = wide[DATA_W];
    alu_rsp.zero   = (wide[DATA_W-1:0] == '0);
  end

  // Chain carry follows only accepted arithmetic ops.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
    end else if (accept && is_arith(op)) begin
      carry_q <= alu_rsp.cout;
    end
  end

  alu_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (alu_rsp),
    .pop       (rsp_ready),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Occupancy count and full flag must agree.
  always_comb begin
    if (!reset) assert (fifo_full == (fifo_count == CNT_W'(DEPTH)));
  end

  assign rsp_valid  = ~fifo_empty;
  assign rsp_result = head.result;
  assign rsp_cout   = head.cout;
  assign rsp_zero   = head.zero;
  assign rsp_err    = head.err;
  assign rsp_tag    = head.tag;

endmodule

// File: doc/alu_cmd_server.md
ALU_CMD_SERVER -- requirements
Module: alu_cmd_server

Interface
REQ-001 Parameter DEPTH, default 4, meaning response FIFO entries (power of two, min 2).
REQ-002 Port clk  input  1  rising-edge clock.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port req_valid  input  1  request present.
REQ-005 Port req_ready  output  1  request accepted this cycle if req_valid high.
REQ-006 Port req_op  input  3  opcode (alu_cmd_pkg::op_e).
REQ-007 Port req_a / req_b  input  16 each  operands.
REQ-008 Port req_cin  input  1  carry/borrow in when req_chain=0.
REQ-009 Port req_chain  input  1  use stored carry instead of req_cin.
REQ-010 Port req_tag  input  4  opaque ID, echoed.
REQ-011 Port rsp_valid  output  1  response at FIFO head.
REQ-012 Port rsp_ready  input  1  consumer takes response.
REQ-013 Port rsp_result  output  16  result.
REQ-014 Port rsp_cout  output  1  carry-out/borrow-out.
REQ-015 Port rsp_zero  output  1  rsp_result == 16'h0000.
REQ-016 Port rsp_err  output  1  illegal opcode.
REQ-017 Port rsp_tag  output  4  echoed req_tag.

Function
REQ-018 Opcodes SHALL be: 0 ADD, 1 SUB, 2 INC, 3 AND, 4 OR, 5 XOR, 6 PASS_A, 7 illegal.
REQ-019 Effective carry c SHALL be carry_q when req_chain=1, else req_cin.
REQ-020 ADD: {cout,result} = a + b + c, 17-bit sum.
REQ-021 SUB: result = a - b - c mod 2^16; cout = 1 iff a < b + c (borrow).
REQ-022 INC: {cout,result} = a + 1; c, req_b ignored.
REQ-023 AND/OR/XOR: bitwise a,b; PASS_A: result = a; cout = 0 for all four.
REQ-024 Illegal opcode: result 16'h0000, cout 0, err 1; otherwise err 0.
REQ-025 Handshake: request accepted iff req_valid && req_ready; response consumed iff rsp_valid && rsp_ready.
REQ-026 req_ready SHALL be (count < DEPTH), registered-state only, no combinational path from rsp_ready.
REQ-027 Result computed in accept cycle and pushed into FIFO; rsp_valid high exactly one cycle after accept into an empty FIFO.
REQ-028 Responses SHALL leave strictly in acceptance order; outputs held stable while rsp_valid && !rsp_ready.
REQ-029 Simultaneous push and pop SHALL keep count unchanged; pointers wrap modulo DEPTH.
REQ-030 carry_q SHALL update to cout on every accepted ADD/SUB/INC; unchanged on logic, PASS_A, illegal ops or no accept.
REQ-031 rsp_* fields SHALL be 0 when rsp_valid=0.

Reset
REQ-032 On reset: count 0, pointers 0, carry_q 0, rsp_valid 0, all rsp_* 0, req_ready 0 during reset cycle, 1 the cycle after.
REQ-033 Reset mid-operation SHALL discard all queued responses; no partial response emitted.

Structure
REQ-034 Package alu_cmd_pkg SHALL hold op_e enum, DATA_W=16, TAG_W=4, rsp_t struct {result,cout,zero,err,tag}.
REQ-035 One sub-module alu_rsp_fifo (synchronous FIFO of rsp_t, DEPTH param, count/full/empty outputs); datapath and carry_q in top.

Verification
REQ-036 ADD a=FFFF b=0001 cin=0 -> next cycle result 0000, cout 1, zero 1, err 0.
REQ-037 ADD a=FFFF b=0001 cin=0, then ADD chain=1 a=0000 b=0000 -> second result 0001, cout 0.
REQ-038 SUB a=0003 b=0005 cin=0 -> FFFE cout 1; then SUB chain=1 a=0001 b=0000 -> 0000, zero 1, cout 0.
REQ-039 rsp_ready=0, five back-to-back requests tags 0..4 -> req_ready low after 4 accepts; raise rsp_ready -> tags 0,1,2,3,4 in order, tag 4 accepted cycle after first pop.
REQ-040 Three queued responses, reset one cycle -> rsp_valid 0 next cycle, carry_q 0, no queued tag reappears.
REQ-041 op=7 a=1234 b=5678 after carry-producing ADD -> result 0000, err 1; following ADD chain=1 0000+0000 -> 0001.
